ahb_lite_slave_fir: RTL
=======================

Name: ahb_lite_slave_fir

Overview:
AHB-Lite slave register front-end for the FIR filter datapath. It decodes bus transfers into a 16-byte register map: status, result, new sample, four coefficients F0-F3 and the coefficient-set control byte. It drives the sample/data_ready and coefficient interfaces of the FIR core and coefficient loader. It sits directly upstream of the FIR core inside ahb_lite_fir_filter.

Parameters:
- NUM_COEFFS, 4, number of coefficient registers (F0..F3), fixed map at 0x6-0xD
- DATA_W, 16, bus and datapath width in bits

Ports:
- clk  in  1  system clock, rising edge
- n_rst  in  1  asynchronous active-low reset
- hsel  in  1  slave select
- haddr  in  4  byte address
- hsize  in  1  0 = byte, 1 = halfword
- htrans  in  2  00 IDLE, 10 NONSEQ; other codes are treated as IDLE
- hwrite  in  1  1 = write
- hwdata  in  16  write data, valid in the data phase
- hrdata  out  16  read data, valid in the data phase
- hresp  out  1  error response
- modwait  in  1  FIR core busy
- fir_out  in  16  FIR result
- err  in  1  FIR overflow/error flag
- coefficient_num  in  2  coefficient index requested by the loader
- coeff_load_done  in  1  one-cycle pulse from the loader when F3 has been loaded
- sample_data  out  16  current sample register
- data_ready  out  1  new-sample strobe
- fir_coefficient  out  16  selected coefficient value
- new_coefficient_set  out  1  request to the loader to load the coefficients

Behaviour:
- Reset (async, n_rst=0): all registers clear to 0.
  - Outputs: hrdata=0, hresp=0, data_ready=0, new_coefficient_set=0, sample_data=0, fir_coefficient=0.
- Pipeline:
  - The address phase is captured when hsel=1 and htrans=NONSEQ. The captured fields are haddr, hsize and hwrite.
  - The data phase is the following cycle. Write data is taken from hwdata in that cycle.
  - hrdata is combinational from the registers during the data phase.
- Register map:
  - 0x0 status: bit0 busy = modwait | data_ready | new_coefficient_set.
  - 0x1 status: bit0 = err; other bits read 0.
  - 0x2-0x3 result (RO).
  - 0x4-0x5 sample (RW).
  - 0x6-0xD F0..F3 (RW, little-endian).
  - 0xE coefficient-set (RW, bit0 only).
  - 0xF reserved.
- Sizes:
  - Byte access: even address = low byte, odd address = high byte. Byte reads return the byte in its lane and 0 in the other lane.
  - Halfword access: uses the even address. A halfword access to an odd address is an error.
- Errors: hresp=1 for the data-phase cycle of any of the following, and the register state is unchanged:
  - write to 0x0-0x3
  - any access to 0xF
  - misaligned halfword
  - halfword access to 0xE
- hresp timing: 0 otherwise, including IDLE cycles and when hsel=0.
- Result register: captures fir_out on each modwait 1->0 transition.
- Sample write:
  - Any write touching 0x4/0x5 updates the sample register at the end of its data phase.
  - data_ready is high for exactly the next cycle.
- Coefficient set:
  - A write of bit0=1 to 0xE sets new_coefficient_set the following cycle.
  - It stays high until coeff_load_done, then clears the cycle after that.
  - Simultaneous coeff_load_done and a write of 1: the write wins and the bit stays 1.
- fir_coefficient = F[coefficient_num], combinational.
- Read-after-write forwarding: a read in the data phase immediately after a write to the same byte returns the new value.
- Back-to-back transfers: the address phase of transfer N+1 overlaps the data phase of N with no wait states. hready is not used.
- Reset mid-transfer: the pending transfer is dropped and all state is cleared.

Test Plan:
- Reset, then read 0x0 halfword -> hrdata=0x0000, hresp=0. Read 0x2 -> 0x0000.
- Halfword writes 0x4000/0x8000/0x8000/0x4000 to 0x6/0x8/0xA/0xC, then halfword reads -> same values returned. Drive coefficient_num=0..3 -> fir_coefficient follows.
- Byte write 0x01 to 0xE:
  - new_coefficient_set=1 next cycle.
  - Status reads busy=1.
  - Pulse coeff_load_done -> new_coefficient_set=0 one cycle later.
- Halfword write 100 (0x0064) to 0x4:
  - data_ready high for one cycle, sample_data=0x0064.
  - Model modwait 1 then 0 with fir_out=50 -> read 0x2 returns 0x0032.
- Errors:
  - Write 0x1234 to 0x2, halfword read at 0x5, access to 0xF -> hresp=1 for each; registers unchanged.
  - Byte read 0x7 after F0=0x4000 -> hrdata=0x4000 (high lane).
- Back-to-back: write 0xAAAA to 0x6 immediately followed by a read of 0x6 -> 0xAAAA. Assert n_rst mid-sequence -> all outputs 0 immediately.

Source files
------------

// File: rtl/ahb_lite_slave_fir_if.sv
// AHB-Lite bus bundle between a master and the FIR register front-end.
//   hsel    - slave select
//   haddr   - byte address (16-byte map)
//   hsize   - 0 = byte, 1 = halfword
//   htrans  - 2'b10 NONSEQ starts a transfer, anything else is idle
//   hwrite  - 1 = write
//   hwdata  - write data, valid in the data phase
//   hrdata  - read data, valid in the data phase
//   hresp   - error response for the data phase
interface ahb_lite_slave_fir_if;
  logic        hsel;
  logic [3:0]  haddr;
  logic        hsize;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [15:0] hwdata;
  logic [15:0] hrdata;
  logic        hresp;

  modport master (
    output hsel, haddr, hsize, htrans, hwrite, hwdata,
    input  hrdata, hresp
  );

  modport slave (
    input  hsel, haddr, hsize, htrans, hwrite, hwdata,
    output hrdata, hresp
  );
endinterface

// File: rtl/ahb_lite_slave_fir.sv
// AHB-Lite slave register front-end for the FIR datapath.
// Byte map: 0x0 busy, 0x1 err, 0x2-0x3 result (RO), 0x4-0x5 sample,
// 0x6-0xD coefficients F0..F3 (little-endian), 0xE coefficient-set bit0, 0xF reserved.
// Ports:
//   clk, n_rst          - clock (rising edge), async active-low reset
//   bus                 - AHB-Lite slave side (hsel/haddr/hsize/htrans/hwrite/hwdata/hrdata/hresp)
//   modwait             - FIR core busy; result is captured on its falling transition
//   fir_out, err        - FIR result and overflow/error flag
//   coefficient_num     - coefficient index requested by the loader
//   coeff_load_done     - loader finished, clears new_coefficient_set
//   sample_data         - sample register
//   data_ready          - one-cycle strobe after a sample write
//   fir_coefficient     - F[coefficient_num]
//   new_coefficient_set - coefficient load request
module ahb_lite_slave_fir #(
  parameter int unsigned NUM_COEFFS = 4,
  parameter int unsigned DATA_W     = 16
) (
  input  logic                          clk,
  input  logic                          n_rst,
  ahb_lite_slave_fir_if.slave           bus,
  input  logic                          modwait,
  input  logic [DATA_W-1:0]             fir_out,
  input  logic                          err,
  input  logic [$clog2(NUM_COEFFS)-1:0] coefficient_num,
  input  logic                          coeff_load_done,
  output logic [DATA_W-1:0]             sample_data,
  output logic                          data_ready,
  output logic [DATA_W-1:0]             fir_coefficient,
  output logic                          new_coefficient_set
);

  localparam logic [1:0] HtransNonseq = 2'b10;
  localparam int         CoeffIdxW    = $clog2(NUM_COEFFS);
  localparam int         RwFirst      = 4;
  localparam int         FirstCoeff   = 6;
  localparam int         RwLast       = FirstCoeff + 2 * NUM_COEFFS - 1;
  localparam logic [3:0] AddrCset     = 4'hE;
  localparam logic [3:0] AddrRsvd     = 4'hF;

  // Captured address phase
  logic       dp_valid_q, dp_valid_d;
  logic [3:0] dp_addr_q, dp_addr_d;
  logic       dp_size_q, dp_size_d;
  logic       dp_write_q, dp_write_d;

  // Register state
  logic [7:0]        rw_q [RwFirst:RwLast];
  logic [7:0]        rw_d [RwFirst:RwLast];
  logic [DATA_W-1:0] result_q, result_d;
  logic              modwait_q;
  logic              data_ready_q, data_ready_d;
  logic              ncs_q, ncs_d;

  logic       bus_err;
  logic       wr_ok;
  logic       rd_ok;
  logic       busy;
  logic [7:0] rd_byte [16];

  always_comb begin
    dp_valid_d = bus.hsel && (bus.htrans == HtransNonseq);
    dp_addr_d  = dp_valid_d ? bus.haddr  : dp_addr_q;
    dp_size_d  = dp_valid_d ? bus.hsize  : dp_size_q;
    dp_write_d = dp_valid_d ? bus.hwrite : dp_write_q;
  end

  // Errors: writes to status/result, anything at 0xF, misaligned halfwords and
  // halfwords at 0xE (the coefficient-set byte has no partner).
  always_comb begin
    bus_err = dp_valid_q &&
              ((dp_write_q && (dp_addr_q[3:2] == 2'b00)) ||
               (dp_addr_q == AddrRsvd) ||
               (dp_size_q && (dp_addr_q[0] || (dp_addr_q == AddrCset))));
    wr_ok   = dp_valid_q && dp_write_q && !bus_err;
    rd_ok   = dp_valid_q && !dp_write_q && !bus_err;
  end

  assign bus.hresp = bus_err;

  // Byte-lane writes: halfwords hit both bytes of the pair, bytes hit one lane.
  always_comb begin
    for (int i = RwFirst; i <= RwLast; i++) begin
      rw_d[i] = rw_q[i];
      if (wr_ok && (dp_size_q ? (dp_addr_q[3:1] == i[3:1]) : (dp_addr_q == i[3:0]))) begin
        rw_d[i] = i[0] ? bus.hwdata[15:8] : bus.hwdata[7:0];
      end
    end
  end

  always_comb begin
    data_ready_d = wr_ok && (dp_addr_q[3:1] == 3'b010);
    result_d     = (modwait_q && !modwait) ? fir_out : result_q;
    // A write in the same cycle as coeff_load_done takes priority.
    ncs_d        = ncs_q;
    if (wr_ok && (dp_addr_q == AddrCset)) begin
      ncs_d = bus.hwdata[0];
    end else if (coeff_load_done) begin
      ncs_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      dp_valid_q   <= 1'b0;
      dp_addr_q    <= '0;
      dp_size_q    <= 1'b0;
      dp_write_q   <= 1'b0;
      result_q     <= '0;
      modwait_q    <= 1'b0;
      data_ready_q <= 1'b0;
      ncs_q        <= 1'b0;
      for (int i = RwFirst; i <= RwLast; i++) begin
        rw_q[i] <= '0;
      end
    end else begin
      dp_valid_q   <= dp_valid_d;
      dp_addr_q    <= dp_addr_d;
      dp_size_q    <= dp_size_d;
      dp_write_q   <= dp_write_d;
      result_q     <= result_d;
      modwait_q    <= modwait;
      data_ready_q <= data_ready_d;
      ncs_q        <= ncs_d;
      for (int i = RwFirst; i <= RwLast; i++) begin
        rw_q[i] <= rw_d[i];
      end
    end
  end

  assign data_ready          = data_ready_q;
  assign new_coefficient_set = ncs_q;
  assign sample_data         = {rw_q[5], rw_q[4]};
  assign busy                = modwait | data_ready_q | ncs_q;

  always_comb begin
    fir_coefficient = '0;
    for (int n = 0; n < NUM_COEFFS; n++) begin
      if (coefficient_num == CoeffIdxW'(n)) begin
        fir_coefficient = {rw_q[FirstCoeff + 2 * n + 1], rw_q[FirstCoeff + 2 * n]};
      end
    end
  end

  // Byte view of the whole map for the read mux.
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      rd_byte[i] = '0;
    end
    rd_byte[0] = {7'b0, busy};
    rd_byte[1] = {7'b0, err};
    rd_byte[2] = result_q[7:0];
    rd_byte[3] = result_q[15:8];
    for (int i = RwFirst; i <= RwLast; i++) begin
      rd_byte[i] = rw_q[i];
    end
    rd_byte[14] = {7'b0, ncs_q};
  end

  always_comb begin
    bus.hrdata = '0;
    if (rd_ok) begin
      if (dp_size_q) begin
        bus.hrdata = {rd_byte[{dp_addr_q[3:1], 1'b1}], rd_byte[{dp_addr_q[3:1], 1'b0}]};
      end else if (dp_addr_q[0]) begin
        bus.hrdata[15:8] = rd_byte[dp_addr_q];
      end else begin
        bus.hrdata[7:0] = rd_byte[dp_addr_q];
      end
    end
  end

endmodule
